// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sp_ram_arbiter
//  Purpose  : Two-port req/gnt/rvalid arbiter in front of one single-port RAM.
//             Optional round-robin under macro SP_RAM_ARB_ROUND_ROBIN_EN.
//  Revision : 1.0  initial release
// ============================================================================
module sp_ram_arbiter #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    logic                  w_sel_p1;
    logic                  w_xfer;
    logic                  r_valid;
    logic                  r_owner;
    logic [DATA_WIDTH-1:0] r_p0_hold;
    logic [DATA_WIDTH-1:0] r_p1_hold;

`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
    logic r_rr_ptr;

    // Pointer names the port preferred on the next contention.
    assign w_sel_p1 = rstn_i & p1_req_i & (~p0_req_i | r_rr_ptr);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rr_ptr <= 1'b0;
        end else if (w_xfer) begin
            r_rr_ptr <= ~w_sel_p1;
        end
    end
`else
    assign w_sel_p1 = rstn_i & p1_req_i & ~p0_req_i;
`endif

    // Grants are gated by reset so nothing is issued while rstn_i is low.
    assign p1_gnt_o = w_sel_p1;
    assign p0_gnt_o = rstn_i & p0_req_i & ~w_sel_p1;
    assign w_xfer   = p0_gnt_o | p1_gnt_o;
    assign ram_en_o = w_xfer;

    always_comb begin
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (p1_gnt_o) begin
            ram_addr_o  = p1_addr_i;
            ram_we_o    = p1_we_i;
            ram_be_o    = p1_be_i;
            ram_wdata_o = p1_wdata_i;
        end else if (p0_gnt_o) begin
            ram_addr_o  = p0_addr_i;
            ram_we_o    = p0_we_i;
            ram_be_o    = p0_be_i;
            ram_wdata_o = p0_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid   <= 1'b0;
            r_owner   <= 1'b0;
            r_p0_hold <= '0;
            r_p1_hold <= '0;
        end else begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_owner <= w_sel_p1;
            end
            if (p0_rvalid_o) begin
                r_p0_hold <= ram_rdata_i;
            end
            if (p1_rvalid_o) begin
                r_p1_hold <= ram_rdata_i;
            end
        end
    end

    // RAM data arrives one cycle after the access; the idle port keeps its last word.
    assign p0_rvalid_o = r_valid & ~r_owner;
    assign p1_rvalid_o = r_valid & r_owner;
    assign p0_rdata_o  = p0_rvalid_o ? ram_rdata_i : r_p0_hold;
    assign p1_rdata_o  = p1_rvalid_o ? ram_rdata_i : r_p1_hold;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// Testbench for sp_ram_arbiter: directed vector table, reset corner cases and
// randomized traffic checked against a transaction-level reference model.
module tb_sp_ram_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        p0_req, p0_gnt, p0_we, p0_rvalid;
    logic [14:0] p0_addr;
    logic [3:0]  p0_be;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_req, p1_gnt, p1_we, p1_rvalid;
    logic [14:0] p1_addr;
    logic [3:0]  p1_be;
    logic [31:0] p1_wdata, p1_rdata;
    logic        ram_en, ram_we;
    logic [14:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata, ram_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sp_ram_arbiter dut (
        .clk(clk), .rstn_i(rstn),
        .p0_req_i(p0_req), .p0_gnt_o(p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
        .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_gnt_o(p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
        .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // Behavioural single-port RAM with one cycle read latency
    logic [31:0] ram_mem [8192];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram_mem[ram_addr[14:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram_mem[ram_addr[14:2]];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [8192];
    bit          pend_v, pend_port, pend_rd;
    logic [31:0] pend_data;
    logic [31:0] hold [2];
    bit          hold_k [2];
    bit          pref;
    int          exp_g;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend_v = 0;
        pref   = 0;
        for (int p = 0; p < 2; p++) begin
            hold[p]   = '0;
            hold_k[p] = 1;
        end
    endtask

    task automatic set_p0(input logic r, input logic [14:0] a, input logic w,
                          input logic [3:0] be, input logic [31:0] d);
        p0_req = r; p0_addr = a; p0_we = w; p0_be = be; p0_wdata = d;
    endtask

    task automatic set_p1(input logic r, input logic [14:0] a, input logic w,
                          input logic [3:0] be, input logic [31:0] d);
        p1_req = r; p1_addr = a; p1_we = w; p1_be = be; p1_wdata = d;
    endtask

    task automatic eval_check();
        logic [14:0] ea;
        logic        ew;
        logic [3:0]  eb;
        logic [31:0] ed;
        #1;
        if (p0_req && p1_req) begin
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
            exp_g = int'(pref);
`else
            exp_g = 0;
`endif
        end else if (p0_req) exp_g = 0;
        else if (p1_req)     exp_g = 1;
        else                 exp_g = -1;
        ea = '0; ew = 1'b0; eb = '0; ed = '0;
        if (exp_g == 0) begin ea = p0_addr; ew = p0_we; eb = p0_be; ed = p0_wdata; end
        if (exp_g == 1) begin ea = p1_addr; ew = p1_we; eb = p1_be; ed = p1_wdata; end
        chk("gnt0", 32'(p0_gnt), 32'(exp_g == 0));
        chk("gnt1", 32'(p1_gnt), 32'(exp_g == 1));
        chk("ram_en", 32'(ram_en), 32'(exp_g >= 0));
        chk("ram_addr", 32'(ram_addr), 32'(ea));
        chk("ram_we", 32'(ram_we), 32'(ew));
        chk("ram_be", 32'(ram_be), 32'(eb));
        chk("ram_wdata", ram_wdata, ed);
        chk("rvalid0", 32'(p0_rvalid), 32'(pend_v && pend_port == 0));
        chk("rvalid1", 32'(p1_rvalid), 32'(pend_v && pend_port == 1));
        for (int p = 0; p < 2; p++) begin
            logic [31:0] act;
            act = (p == 0) ? p0_rdata : p1_rdata;
            if (pend_v && pend_port == p[0]) begin
                if (pend_rd) chk(p == 0 ? "rdata0" : "rdata1", act, pend_data);
            end else if (hold_k[p]) begin
                chk(p == 0 ? "hold0" : "hold1", act, hold[p]);
            end
        end
    endtask

    task automatic advance();
        logic [14:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        if (pend_v) begin
            if (pend_rd) begin
                hold[pend_port]   = pend_data;
                hold_k[pend_port] = 1;
            end else begin
                hold_k[pend_port] = 0;
            end
        end
        pend_v = (exp_g >= 0);
        if (pend_v) begin
            a  = (exp_g == 0) ? p0_addr : p1_addr;
            be = (exp_g == 0) ? p0_be : p1_be;
            d  = (exp_g == 0) ? p0_wdata : p1_wdata;
            pend_port = exp_g[0];
            pend_rd   = (exp_g == 0) ? !p0_we : !p1_we;
            pend_data = ref_mem[a[14:2]];
            if (!pend_rd)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a[14:2]][8*b +: 8] = d[8*b +: 8];
            pref = (exp_g == 0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        r0; logic [14:0] a0; logic w0; logic [3:0] b0; logic [31:0] d0;
        logic        r1; logic [14:0] a1; logic w1; logic [3:0] b1; logic [31:0] d1;
        logic [1:0]  eg;      // {gnt1, gnt0}
        logic [1:0]  erv;     // {rvalid1, rvalid0}
        bit          chk_rv;
        bit          chk_rd;
        logic [31:0] erd;
    } vec_t;

    vec_t vec [20];

    function automatic vec_t mk(logic r0, logic [14:0] a0, logic w0, logic [3:0] b0, logic [31:0] d0,
                                logic r1, logic [14:0] a1, logic w1, logic [3:0] b1, logic [31:0] d1,
                                logic [1:0] eg, logic [1:0] erv, bit crv, bit crd, logic [31:0] erd);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.w0 = w0; v.b0 = b0; v.d0 = d0;
        v.r1 = r1; v.a1 = a1; v.w1 = w1; v.b1 = b1; v.d1 = d1;
        v.eg = eg; v.erv = erv; v.chk_rv = crv; v.chk_rd = crd; v.erd = erd;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 8192; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ram_rdata = '0;
        vec[0]  = mk(1, 15'h10, 1, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 0);
        vec[1]  = mk(0, 0, 0, 0, 0, 1, 15'h10, 0, 4'hF, 0, 2'b10, 2'b01, 1, 0, 0);
        vec[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 1, 32'hDEADBEEF);
        vec[3]  = mk(1, 15'h20, 1, 4'hF, 32'h11223344, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 0);
        vec[4]  = mk(0, 0, 0, 0, 0, 1, 15'h20, 1, 4'h2, 32'h0000AB00, 2'b10, 2'b01, 1, 0, 0);
        vec[5]  = mk(0, 0, 0, 0, 0, 1, 15'h20, 0, 4'hF, 0, 2'b10, 2'b10, 1, 0, 0);
        vec[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 1, 32'h1122AB44);
        vec[7]  = mk(0, 0, 0, 0, 0, 1, 15'h0, 1, 4'hF, 32'h10000000, 2'b10, 2'b00, 1, 0, 0);
        vec[8]  = mk(0, 0, 0, 0, 0, 1, 15'h4, 1, 4'hF, 32'h20000004, 2'b10, 2'b10, 1, 0, 0);
        vec[9]  = mk(0, 0, 0, 0, 0, 1, 15'h8, 1, 4'hF, 32'h30000008, 2'b10, 2'b10, 1, 0, 0);
        vec[10] = mk(1, 15'h0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 1, 0, 0);
        vec[11] = mk(1, 15'h4, 0, 4'hF, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1, 1, 32'h10000000);
        vec[12] = mk(1, 15'h8, 0, 4'hF, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1, 1, 32'h20000004);
        vec[13] = mk(0, 0, 0, 0, 0, 1, 15'h8, 0, 4'hF, 0, 2'b10, 2'b01, 1, 1, 32'h30000008);
        for (int i = 14; i < 20; i++) begin
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
            vec[i] = mk(1, 15'h0, 0, 4'hF, 0, 1, 15'h4, 0, 4'hF, 0,
                        (i % 2 == 0) ? 2'b01 : 2'b10, 2'b10, i == 14, i == 14, 32'h30000008);
`else
            vec[i] = mk(1, 15'h0, 0, 4'hF, 0, 1, 15'h4, 0, 4'hF, 0,
                        2'b01, 2'b10, i == 14, i == 14, 32'h30000008);
`endif
        end

        // Reset with both ports requesting
        rstn = 1'b0;
        set_p0(1, 15'h10, 1, 4'hF, 32'hDEADBEEF);
        set_p1(1, 15'h40, 0, 4'hF, 0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'({p1_gnt, p0_gnt}), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
        chk("rst_rdata0", p0_rdata, 32'd0);
        chk("rst_rdata1", p1_rdata, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            set_p0(vec[i].r0, vec[i].a0, vec[i].w0, vec[i].b0, vec[i].d0);
            set_p1(vec[i].r1, vec[i].a1, vec[i].w1, vec[i].b1, vec[i].d1);
            eval_check();
            chk($sformatf("vec%0d_gnt", i), 32'({p1_gnt, p0_gnt}), 32'(vec[i].eg));
            if (vec[i].chk_rv)
                chk($sformatf("vec%0d_rv", i), 32'({p1_rvalid, p0_rvalid}), 32'(vec[i].erv));
            if (vec[i].chk_rd)
                chk($sformatf("vec%0d_rd", i), vec[i].erv[1] ? p1_rdata : p0_rdata, vec[i].erd);
            advance();
        end

        // Randomized traffic; a request stays stable until granted or dropped
        for (int n = 0; n < 400; n++) begin
            if (!(p0_req && exp_g != 0 && $urandom_range(3) != 0)) begin
                set_p0(1'($urandom_range(1)), 15'({$urandom_range(31), 2'b00}) | 15'($urandom_range(3)),
                       1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
            end
            if (!(p1_req && exp_g != 1 && $urandom_range(3) != 0)) begin
                set_p1(1'($urandom_range(1)), 15'({$urandom_range(31), 2'b00}) | 15'($urandom_range(3)),
                       1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
            end
            eval_check();
            advance();
        end

        // Reset in the cycle after a granted read drops the response
        set_p0(0, 0, 0, 0, 0);
        set_p1(0, 0, 0, 0, 0);
        eval_check();
        advance();
        set_p0(1, 15'h0, 0, 4'hF, 0);
        eval_check();
        advance();
        rstn = 1'b0;
        set_p0(0, 0, 0, 0, 0);
        #1;
        chk("midrst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
        chk("midrst_rdata0", p0_rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        eval_check();
        chk("post_rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
        advance();
        set_p0(1, 15'h4, 0, 4'hF, 0);
        eval_check();
        advance();
        set_p0(0, 0, 0, 0, 0);
        eval_check();
        chk("post_rst_read_rv", 32'(p0_rvalid), 32'd1);
        chk("post_rst_read_rd", p0_rdata, ref_mem[1]);
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
